// File: rtl/wb_stream_pkg.sv
// Shared definitions for the Wishbone stream DMA blocks.
//   - register offsets as decoded from the config address bits [4:2]
//   - CTRL / STATUS bit positions
//   - Wishbone cycle type identifiers for incrementing bursts
//   - state encoding of the burst-read FSM
//   - clamp_burst(): maps a programmed burst size onto 1..max_len
package wb_stream_pkg;

    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_START_ADDR = 3'd1;
    localparam logic [2:0] REG_BUF_SIZE   = 3'd2;
    localparam logic [2:0] REG_BURST_SIZE = 3'd3;
    localparam logic [2:0] REG_STATUS     = 3'd4;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CYCLIC = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_EOB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    // A burst size of 0 behaves as single-beat bursts; oversize values saturate.
    function automatic logic [31:0] clamp_burst(input logic [31:0] size,
                                                input logic [31:0] max_len);
        if (size == 32'd0)
            return 32'd1;
        else if (size > max_len)
            return max_len;
        else
            return size;
    endfunction

endpackage

// File: rtl/wb_stream_fifo.sv
// First-word-fall-through FIFO: dout always shows the oldest entry while
// !empty, so a consumer may treat !empty as "valid".
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   din, wr           write data / write strobe (ignored when full)
//   dout, rd          head data / pop strobe (ignored when empty)
//   empty, full       status flags
//   count             occupancy in words (0 .. 2**AW)
module wb_stream_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr,
    output logic [WIDTH-1:0] dout,
    input  logic             rd,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/wb_stream_dma_writer.sv
// Wishbone burst-read DMA feeding a valid/ready stream.
// A Wishbone master reads START_ADDR..START_ADDR+BUF_SIZE in incrementing
// bursts into an internal FWFT FIFO which drives the stream output.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wbm_*           Wishbone master (read-only, linear incrementing bursts)
//   wbs_*           Wishbone slave for the register file
//   stream_m_*      stream output; a word moves on a clock edge where
//                   valid and ready are both high, and data/valid stay put
//                   while valid is high and ready is low
//   irq_o           level interrupt: (done | err) & irq_en
module wb_stream_dma_writer
    import wb_stream_pkg::*;
#(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 5,
    parameter int MAX_BURST_LEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               wbm_rty_i,
    input  logic [WB_AW-1:0]   wbs_adr_i,
    input  logic [WB_DW-1:0]   wbs_dat_i,
    input  logic [WB_DW/8-1:0] wbs_sel_i,
    input  logic               wbs_we_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic [2:0]         wbs_cti_i,
    input  logic [1:0]         wbs_bte_i,
    output logic [WB_DW-1:0]   wbs_dat_o,
    output logic               wbs_ack_o,
    output logic               wbs_err_o,
    output logic               wbs_rty_o,
    output logic [WB_DW-1:0]   stream_m_data_o,
    output logic               stream_m_valid_o,
    input  logic               stream_m_ready_i,
    output logic               irq_o
);

    localparam int WSB   = WB_DW / 8;
    localparam int BSH   = $clog2(WSB);
    localparam int BLW   = $clog2(MAX_BURST_LEN + 1);
    localparam int DEPTH = 1 << FIFO_AW;

    // Programmer-visible registers
    logic             ctrl_enable;
    logic             ctrl_cyclic;
    logic             ctrl_irq_en;
    logic [WB_AW-1:0] start_addr;
    logic [WB_DW-1:0] buf_size;
    logic [WB_DW-1:0] burst_size;
    logic             st_done;
    logic             st_err;

    // Working copies taken at LOAD so config writes never disturb a pass
    state_t           state;
    logic [WB_AW-1:0] cur_addr;
    logic [WB_DW-1:0] remaining;
    logic [BLW-1:0]   burst_len;
    logic [BLW-1:0]   blen;
    logic [BLW-1:0]   beat;
    logic             cyc;
    logic             wbs_ack;
    logic [WB_DW-1:0] wbs_rdata;

    logic [WB_DW-1:0] reg_rdata;
    logic [BLW-1:0]   wait_blen;
    logic [FIFO_AW:0] fifo_count;
    logic [FIFO_AW:0] fifo_free;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_wr;
    logic             busy;
    logic             last_beat;

    assign busy      = (state != ST_IDLE);
    assign last_beat = (beat == blen - 1'b1);
    assign fifo_free = (FIFO_AW+1)'(DEPTH) - fifo_count;
    // Error beats carry no valid data and are never pushed.
    assign fifo_wr   = cyc && wbm_ack_i && !wbm_err_i;

    always_comb begin
        if (remaining < WB_DW'(burst_len))
            wait_blen = remaining[BLW-1:0];
        else
            wait_blen = burst_len;
    end

    always_comb begin
        reg_rdata = '0;
        case (wbs_adr_i[4:2])
            REG_CTRL:       reg_rdata = WB_DW'({ctrl_irq_en, ctrl_cyclic, ctrl_enable});
            REG_START_ADDR: reg_rdata = WB_DW'(start_addr);
            REG_BUF_SIZE:   reg_rdata = buf_size;
            REG_BURST_SIZE: reg_rdata = burst_size;
            REG_STATUS:     reg_rdata = WB_DW'({st_err, st_done, busy});
            default:        reg_rdata = '0;
        endcase
    end

    // FSM and register file share one block because both may change
    // enable/done/err; the config write comes last so a bus write in the
    // same cycle as an FSM update wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ctrl_enable <= 1'b0;
            ctrl_cyclic <= 1'b0;
            ctrl_irq_en <= 1'b0;
            start_addr  <= '0;
            buf_size    <= '0;
            burst_size  <= '0;
            st_done     <= 1'b0;
            st_err      <= 1'b0;
            cur_addr    <= '0;
            remaining   <= '0;
            burst_len   <= '0;
            blen        <= '0;
            beat        <= '0;
            cyc         <= 1'b0;
            wbs_ack     <= 1'b0;
            wbs_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_enable)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    cur_addr  <= start_addr & ~WB_AW'(WSB - 1);
                    remaining <= buf_size >> BSH;
                    burst_len <= BLW'(clamp_burst(32'(burst_size), 32'(MAX_BURST_LEN)));
                    if ((buf_size >> BSH) == '0) begin
                        // Empty buffer: report completion without touching the bus.
                        st_done     <= 1'b1;
                        ctrl_enable <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Nothing is in flight here, so the FIFO count is the
                    // committed occupancy; the whole burst must fit.
                    if (!ctrl_enable)
                        state <= ST_IDLE;
                    else if (32'(fifo_free) >= 32'(wait_blen)) begin
                        blen  <= wait_blen;
                        beat  <= '0;
                        cyc   <= 1'b1;
                        state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (wbm_err_i) begin
                        cyc         <= 1'b0;
                        st_err      <= 1'b1;
                        ctrl_enable <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (wbm_ack_i) begin
                        cur_addr <= cur_addr + WB_AW'(WSB);
                        beat     <= beat + 1'b1;
                        if (last_beat) begin
                            cyc       <= 1'b0;
                            remaining <= remaining - WB_DW'(blen);
                            if (!ctrl_enable)
                                state <= ST_IDLE;
                            else if (remaining != WB_DW'(blen))
                                state <= ST_WAIT;
                            else begin
                                st_done <= 1'b1;
                                if (ctrl_cyclic)
                                    state <= ST_LOAD;
                                else begin
                                    ctrl_enable <= 1'b0;
                                    state       <= ST_IDLE;
                                end
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Config slave: one-cycle ack, then ack low for at least a cycle.
            wbs_ack <= 1'b0;
            if (wbs_cyc_i && wbs_stb_i && !wbs_ack) begin
                wbs_ack   <= 1'b1;
                wbs_rdata <= reg_rdata;
                if (wbs_we_i) begin
                    case (wbs_adr_i[4:2])
                        REG_CTRL: begin
                            ctrl_enable <= wbs_dat_i[CTRL_ENABLE];
                            ctrl_cyclic <= wbs_dat_i[CTRL_CYCLIC];
                            ctrl_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
                        end
                        REG_START_ADDR: start_addr <= WB_AW'(wbs_dat_i);
                        REG_BUF_SIZE:   buf_size   <= wbs_dat_i;
                        REG_BURST_SIZE: burst_size <= wbs_dat_i;
                        REG_STATUS: begin
                            if (wbs_dat_i[STAT_DONE])
                                st_done <= 1'b0;
                            if (wbs_dat_i[STAT_ERR])
                                st_err <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    wb_stream_fifo #(
        .WIDTH (WB_DW),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .din   (wbm_dat_i),
        .wr    (fifo_wr),
        .dout  (stream_m_data_o),
        .rd    (stream_m_valid_o && stream_m_ready_i),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign stream_m_valid_o = !fifo_empty;

    assign wbm_adr_o = cur_addr;
    assign wbm_dat_o = '0;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b0;
    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_cti_o = cyc ? (last_beat ? CTI_EOB : CTI_INC) : 3'b000;
    assign wbm_bte_o = 2'b00;

    assign wbs_dat_o = wbs_rdata;
    assign wbs_ack_o = wbs_ack;
    assign wbs_err_o = 1'b0;
    assign wbs_rty_o = 1'b0;

    assign irq_o = (st_done | st_err) & ctrl_irq_en;

    // Inputs with no function in this block (retry counts as no-ack).
    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_sel_i, wbs_cti_i, wbs_bte_i, wbm_rty_i,
                         wbs_adr_i[WB_AW-1:5], wbs_adr_i[1:0], fifo_full};

endmodule

// File: tb/tb_wb_stream_dma_writer.sv
module tb_wb_stream_dma_writer;

    localparam int MEM_WORDS = 1024;

    logic        clk;
    logic        rst;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        wbs_rty_o;
    logic [31:0] stream_m_data_o;
    logic        stream_m_valid_o;
    logic        stream_m_ready_i;
    logic        irq_o;

    wb_stream_dma_writer #(
        .WB_AW(32), .WB_DW(32), .FIFO_AW(5), .MAX_BURST_LEN(32)
    ) dut (
        .clk(clk), .rst(rst),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i), .wbs_dat_o(wbs_dat_o),
        .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
        .stream_m_data_o(stream_m_data_o), .stream_m_valid_o(stream_m_valid_o),
        .stream_m_ready_i(stream_m_ready_i), .irq_o(irq_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] exp_q[$];       // expected stream words, in order
    logic [31:0] exp_addr_q[$];  // expected address of every acked beat
    int          exp_blen_q[$];  // expected length of every burst
    int          ready_pct = 100;
    int          ack_pct = 75;
    int          err_beat = -1;
    int          beats_total = 0;
    int          words_rx = 0;
    int          cyc_cycles = 0;
    int          burst_beats = 0;
    bit          err_driven = 0;
    bit          hold_pending = 0;
    logic [31:0] hold_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a buffer is a run of consecutive words split into
    // bursts of min(burst, words left); burst 0 means 1, >32 means 32.
    function automatic void model_push(input int unsigned start, input int unsigned bufb,
                                       input int unsigned burst);
        int unsigned words = bufb / 4;
        int unsigned b = (burst == 0) ? 1 : ((burst > 32) ? 32 : burst);
        int unsigned rem = words;
        int unsigned base = start & ~32'd3;
        for (int unsigned i = 0; i < words; i++) begin
            exp_addr_q.push_back(base + 4 * i);
            exp_q.push_back(mem[((base >> 2) + i) % MEM_WORDS]);
        end
        while (rem > 0) begin
            exp_blen_q.push_back((rem < b) ? rem : b);
            rem -= (rem < b) ? rem : b;
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        exp_addr_q.delete();
        exp_blen_q.delete();
    endfunction

    // ---------------- memory slave (responder) ----------------
    initial begin
        wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0; wbm_dat_i = '0;
        forever begin
            @(negedge clk);
            if (err_driven) check("cyc_drop_on_err", wbm_cyc_o, 0);
            err_driven = 0;
            wbm_ack_i = 0;
            wbm_err_i = 0;
            if (wbm_cyc_o) cyc_cycles++;
            if (rst) begin
                burst_beats = 0;
            end else if (wbm_cyc_o && wbm_stb_o) begin
                if (beats_total == err_beat) begin
                    wbm_err_i = 1;
                    err_driven = 1;
                    burst_beats = 0;
                end else if ($urandom_range(0, 99) < ack_pct) begin
                    wbm_ack_i = 1;
                    wbm_dat_i = mem[wbm_adr_o[11:2]];
                    check("beat_expected", exp_addr_q.size() > 0, 1);
                    if (exp_addr_q.size() > 0) check("beat_addr", wbm_adr_o, exp_addr_q.pop_front());
                    beats_total++;
                    burst_beats++;
                    if (wbm_cti_o == 3'b111) begin
                        check("burst_len", burst_beats,
                              (exp_blen_q.size() > 0) ? exp_blen_q.pop_front() : -1);
                        burst_beats = 0;
                    end else begin
                        check("cti_inc", wbm_cti_o, 3'b010);
                    end
                end
            end
        end
    end

    // ---------------- stream sink ----------------
    initial begin
        stream_m_ready_i = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 0;
            end else begin
                if (hold_pending) begin
                    check("hold_valid", stream_m_valid_o, 1);
                    check("hold_data", stream_m_data_o, hold_data);
                end
                stream_m_ready_i = ($urandom_range(0, 99) < ready_pct);
                if (stream_m_valid_o && stream_m_ready_i) begin
                    check("word_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("stream_data", stream_m_data_o, exp_q.pop_front());
                    words_rx++;
                end
                hold_pending = stream_m_valid_o && !stream_m_ready_i;
                hold_data = stream_m_data_o;
            end
        end
    end

    // ---------------- config driver tasks ----------------
    task automatic wb_write(input logic [4:0] off, input logic [31:0] d);
        @(negedge clk);
        wbs_adr_i = 32'(off); wbs_dat_i = d; wbs_we_i = 1; wbs_cyc_i = 1; wbs_stb_i = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wbs_ack_o) break;
        end
        check("wbs_ack_wr", wbs_ack_o, 1);
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    endtask

    task automatic wb_read(input logic [4:0] off, output logic [31:0] d);
        @(negedge clk);
        wbs_adr_i = 32'(off); wbs_we_i = 0; wbs_cyc_i = 1; wbs_stb_i = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wbs_ack_o) break;
        end
        check("wbs_ack_rd", wbs_ack_o, 1);
        d = wbs_dat_o;
        wbs_cyc_i = 0; wbs_stb_i = 0;
    endtask

    task automatic start_run(input logic [31:0] start, input logic [31:0] bufb,
                             input logic [31:0] burst, input logic [31:0] ctrl);
        beats_total = 0;
        words_rx = 0;
        wb_write(5'h04, start);
        wb_write(5'h08, bufb);
        wb_write(5'h0C, burst);
        wb_write(5'h00, ctrl);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            wb_read(5'h10, s);
            if (!s[0] && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check({tag, "_finished"}, ok, 1);
        check({tag, "_addr_left"}, exp_addr_q.size(), 0);
        check({tag, "_bursts_left"}, exp_blen_q.size(), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        bit ok;

        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        rst = 1;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '1; wbs_we_i = 0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_cti_i = '0; wbs_bte_i = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);
        check("rst_valid", stream_m_valid_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_wbs_ack", wbs_ack_o, 0);
        check("rst_adr", wbm_adr_o, 0);
        rst = 0;
        wb_read(5'h10, rd);  check("rst_status", rd, 0);
        wb_read(5'h00, rd);  check("rst_ctrl", rd, 0);
        wb_write(5'h04, 32'h0000_1240);
        @(negedge clk);
        check("wbs_ack_one_cycle", wbs_ack_o, 0);
        wb_read(5'h04, rd);  check("start_readback", rd, 32'h0000_1240);
        wb_read(5'h14, rd);  check("unmapped_read", rd, 0);

        // Full-size bursts, interrupt on completion
        model_push(32'h40, 128, 8);
        start_run(32'h40, 128, 8, 32'h5);
        wait_done("buf128");
        check("buf128_words", words_rx, 32);
        wb_read(5'h10, rd);  check("buf128_status", rd, 32'h2);
        check("buf128_irq", irq_o, 1);
        wb_write(5'h10, 32'h2);
        @(negedge clk);
        check("buf128_irq_clr", irq_o, 0);

        // Short final bursts and clamping
        model_push(32'h100, 20, 8);  start_run(32'h100, 20, 8, 32'h1);  wait_done("buf20");
        model_push(32'h300, 44, 8);  start_run(32'h300, 44, 8, 32'h1);  wait_done("buf44");
        model_push(32'h400, 160, 40); start_run(32'h400, 160, 40, 32'h1); wait_done("clamp40");

        // Backpressure: master must stop once the FIFO cannot take a burst
        ready_pct = 0;
        model_push(32'h800, 256, 8);
        start_run(32'h800, 256, 8, 32'h1);
        repeat (300) @(negedge clk);
        check("stall_beats", beats_total, 32);
        check("stall_cyc", wbm_cyc_o, 0);
        ready_pct = 30;
        wait_done("stall");
        check("stall_words", words_rx, 64);
        ready_pct = 100;

        // Bus error on beat 3 of burst 2 (beat index 11 overall)
        wb_write(5'h10, 32'h6);
        model_push(32'h600, 64, 8);
        while (exp_addr_q.size() > 11) begin
            void'(exp_addr_q.pop_back());
            void'(exp_q.pop_back());
        end
        void'(exp_blen_q.pop_back());
        err_beat = 11;
        start_run(32'h600, 64, 8, 32'h5);
        wait_done("err");
        err_beat = -1;
        check("err_words", words_rx, 11);
        wb_read(5'h10, rd);  check("err_status", rd, 32'h4);
        check("err_irq", irq_o, 1);
        wb_write(5'h10, 32'h4);
        wb_read(5'h10, rd);  check("err_w1c", rd, 32'h0);
        check("err_irq_clr", irq_o, 0);
        wb_read(5'h00, rd);  check("err_enable_cleared", rd, 32'h4);

        // Empty buffer: done without any bus cycle
        cyc_cycles = 0;
        start_run(32'h700, 0, 8, 32'h1);
        repeat (10) @(negedge clk);
        wb_read(5'h10, rd);  check("buf0_status", rd, 32'h2);
        check("buf0_no_cyc", cyc_cycles, 0);
        wb_write(5'h10, 32'h2);

        // Burst size 0: single-beat bursts, each EOB
        model_push(32'h700, 12, 0);
        start_run(32'h700, 12, 0, 32'h1);
        wait_done("burst0");

        // Cyclic mode, stopped by clearing enable
        for (int p = 0; p < 8; p++) model_push(32'h200, 32, 4);
        start_run(32'h200, 32, 4, 32'h3);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (words_rx >= 24) begin ok = 1; break; end
        end
        check("cyclic_3_passes", ok, 1);
        wb_write(5'h00, 32'h0);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            wb_read(5'h10, rd);
            if (!rd[0]) begin ok = 1; break; end
        end
        check("cyclic_stopped", ok, 1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stream_m_valid_o) begin ok = 1; break; end
        end
        check("cyclic_drained", ok, 1);
        check("cyclic_whole_bursts", beats_total % 4, 0);
        check("cyclic_all_streamed", words_rx, beats_total);
        check("cyclic_bounded", beats_total < 64, 1);
        model_clear();

        // Asynchronous reset in the middle of a burst
        ready_pct = 0;
        model_push(32'h900, 128, 8);
        start_run(32'h900, 128, 8, 32'h5);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wbm_cyc_o) begin ok = 1; break; end
        end
        check("rstmid_cyc_seen", ok, 1);
        #2 rst = 1;
        #1;
        check("rstmid_cyc", wbm_cyc_o, 0);
        check("rstmid_stb", wbm_stb_o, 0);
        check("rstmid_cti", wbm_cti_o, 0);
        check("rstmid_valid", stream_m_valid_o, 0);
        check("rstmid_irq", irq_o, 0);
        check("rstmid_adr", wbm_adr_o, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        model_clear();
        ready_pct = 100;
        wb_read(5'h10, rd);  check("rstmid_status", rd, 0);
        wb_read(5'h0C, rd);  check("rstmid_burst_reg", rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
